// File: rtl/ws2812_stream_driver.sv
// ws2812_stream_driver: WS2812 NRZ strip driver, one-pixel prefetch, timed latch; WS2812_BRIGHTNESS_EN adds global brightness scaling
module ws2812_stream_driver #(
  parameter int NUM_LEDS   = 256,
  parameter int COLOR_BITS = 24,
  parameter int T0H_CYC    = 26,
  parameter int T1H_CYC    = 52,
  parameter int BIT_CYC    = 81,
  parameter int RESET_CYC  = 3250
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [COLOR_BITS-1:0] pixel_in,
  input  logic                  pixel_valid_in,
  output logic                  pixel_ready_out,
  input  logic [7:0]            brightness_in,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic                  underrun_out,
  output logic                  comm
);
  localparam int CW = $clog2(BIT_CYC > RESET_CYC ? BIT_CYC : RESET_CYC);
  localparam int BW = $clog2(COLOR_BITS);
  localparam int PW = $clog2(NUM_LEDS + 1);
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, SEND, LATCH} state_t;
  state_t state_q, state_d;
  logic [COLOR_BITS-1:0] buf_q, buf_d, sh_q, sh_d;
  logic full_q, full_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] acc_q, acc_d, sent_q, sent_d;
  logic last_cyc, last_bit;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] br_q;
  always_ff @(posedge clk_in)
    if (rst_in) br_q <= '0;
    else if (state_q == IDLE && start_in) br_q <= brightness_in;
`else
  logic unused_br;
  assign unused_br = ^brightness_in;
`endif
  // Reorders {R,G,...} to the wire order {G,R,...}, scaling each channel when enabled
  function automatic logic [COLOR_BITS-1:0] to_wire(input logic [COLOR_BITS-1:0] p);
    logic [COLOR_BITS-1:0] w;
    w = {p[COLOR_BITS-9 -: 8], p[COLOR_BITS-1 -: 8], p[COLOR_BITS-17:0]};
`ifdef WS2812_BRIGHTNESS_EN
    for (int i = 0; i < COLOR_BITS / 8; i++)
      w[i*8 +: 8] = 8'((16'(w[i*8 +: 8]) * (16'(br_q) + 16'd1)) >> 8);
`endif
    return w;
  endfunction
  assign last_cyc        = cyc_q == CW'(BIT_CYC - 1);
  assign last_bit        = bit_q == BW'(COLOR_BITS - 1);
  assign busy_out        = state_q != IDLE;
  assign pixel_ready_out = (state_q == WAIT_FIRST || state_q == SEND) && !full_q && acc_q < PW'(NUM_LEDS);
  assign comm            = state_q == SEND && cyc_q < (sh_q[COLOR_BITS-1] ? CW'(T1H_CYC) : CW'(T0H_CYC));
  assign frame_done_out  = state_q == LATCH && cyc_q == CW'(RESET_CYC - 1);
  assign underrun_out    = state_q == SEND && last_cyc && last_bit && sent_q != PW'(NUM_LEDS) && !full_q;
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    full_d  = full_q;
    sh_d    = sh_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    acc_d   = acc_q;
    sent_d  = sent_q;
    if (pixel_valid_in && pixel_ready_out) begin
      buf_d  = pixel_in;
      full_d = 1'b1;
      acc_d  = acc_q + 1'b1;
    end
    case (state_q)
      IDLE: if (start_in) begin
        state_d = WAIT_FIRST;
        acc_d   = '0;
        sent_d  = '0;
        full_d  = 1'b0;
        cyc_d   = '0;
        bit_d   = '0;
      end
      WAIT_FIRST: if (full_q) begin
        state_d = SEND;
        sh_d    = to_wire(buf_q);
        full_d  = 1'b0;
        sent_d  = sent_q + 1'b1;
        cyc_d   = '0;
        bit_d   = '0;
      end
      SEND: begin
        cyc_d = last_cyc ? '0 : cyc_q + 1'b1;
        if (last_cyc && !last_bit) begin
          bit_d = bit_q + 1'b1;
          sh_d  = sh_q << 1;
        end else if (last_cyc) begin
          bit_d = '0;
          if (sent_q != PW'(NUM_LEDS) && full_q) begin
            sh_d   = to_wire(buf_q);
            full_d = 1'b0;
            sent_d = sent_q + 1'b1;
          end else state_d = LATCH;
        end
      end
      LATCH: begin
        cyc_d   = frame_done_out ? '0 : cyc_q + 1'b1;
        state_d = frame_done_out ? IDLE : LATCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state_q <= IDLE;
      buf_q   <= '0;
      full_q  <= 1'b0;
      sh_q    <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      acc_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      sh_q    <= sh_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      sent_q  <= sent_d;
    end
endmodule

// File: tb/tb_ws2812_stream_driver.sv
// tb_ws2812_stream_driver: scoreboard bench decoding the strip waveform back into pixel words
module tb_ws2812_stream_driver;
  localparam int N = 2, T0 = 2, T1 = 5, B = 8, R = 20;
`ifdef WS2812_BRIGHTNESS_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, pv, rdy, busy, fd, ur, comm;
  logic [23:0] pix;
  logic [7:0] bright, br_frame;
  logic start32, pv32, rdy32, busy32, fd32, ur32, comm32;
  logic [31:0] pix32;
  always #5 clk = ~clk;
  ws2812_stream_driver #(.NUM_LEDS(N), .COLOR_BITS(24), .T0H_CYC(T0), .T1H_CYC(T1), .BIT_CYC(B), .RESET_CYC(R)) u_dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .pixel_in(pix), .pixel_valid_in(pv),
    .pixel_ready_out(rdy), .brightness_in(bright), .busy_out(busy), .frame_done_out(fd),
    .underrun_out(ur), .comm(comm));
  ws2812_stream_driver #(.NUM_LEDS(1), .COLOR_BITS(32), .T0H_CYC(T0), .T1H_CYC(T1), .BIT_CYC(B), .RESET_CYC(R)) u_dut32 (
    .clk_in(clk), .rst_in(rst), .start_in(start32), .pixel_in(pix32), .pixel_valid_in(pv32),
    .pixel_ready_out(rdy32), .brightness_in(bright), .busy_out(busy32), .frame_done_out(fd32),
    .underrun_out(ur32), .comm(comm32));
  int errs = 0, checks = 0;
  int hs_cnt = 0, fd_cnt = 0, ur_cnt = 0;
  logic hs = 1'b0;
  logic [23:0] feed[$], exp_q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] model(input logic [23:0] p, input logic [7:0] b);
    int k;
    logic [7:0] ch[3];
    k = BR_EN ? int'(b) + 1 : 256;
    ch[0] = p[15:8];
    ch[1] = p[23:16];
    ch[2] = p[7:0];
    for (int i = 0; i < 3; i++) ch[i] = 8'((int'(ch[i]) * k) / 256);
    return {ch[0], ch[1], ch[2]};
  endfunction
  initial begin
    pv = 1'b0;
    pix = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hs && feed.size() > 0) void'(feed.pop_front());
      pv  = feed.size() > 0;
      pix = feed.size() > 0 ? feed[0] : 24'h0;
    end
  end
  initial begin
    int hi, since, nb;
    bit in_frame, prev;
    logic [23:0] w;
    hi = 0; since = 0; nb = 0; in_frame = 0; prev = 0; w = '0;
    forever begin
      @(negedge clk);
      hs = pv && rdy && !rst;
      if (rst) begin
        exp_q.delete();
        nb = 0; hi = 0; in_frame = 0; prev = 0;
      end else begin
        if (hs) begin
          hs_cnt++;
          exp_q.push_back(model(pix, br_frame));
        end
        if (fd) fd_cnt++;
        if (ur) ur_cnt++;
        if (comm && !prev) begin
          if (in_frame) check("bit_period", 32'(since), 32'(B));
          in_frame = 1; since = 0; hi = 0;
        end
        since++;
        if (comm) hi++;
        if (!comm && prev) begin
          check("high_width", 32'(hi == T0 || hi == T1), 32'd1);
          w = {w[22:0], hi == T1};
          nb++;
          if (nb == 24) begin
            nb = 0;
            check("exp_available", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("pixel_word", 32'(w), 32'(exp_q.pop_front()));
          end
        end
        if (fd || ur) in_frame = 0;
        prev = comm;
      end
    end
  end
  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    br_frame = bright;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_rise(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = comm;
    end
    check(tag, 32'(ok), 32'd1);
  endtask
  // n counts cycles from the first SEND cycle through the frame_done cycle inclusive
  task automatic run_frame(output int n, output int nu, output int hi_after);
    n = 1; nu = 0; hi_after = 0;
    while (!fd && n < 2000) begin
      @(negedge clk);
      n++;
      if (ur) nu = n;
      if (nu != 0 && n > nu && comm) hi_after++;
    end
    check("frame_done_seen", 32'(fd), 32'd1);
  endtask
  initial begin
    int n, nu, ha, base, late, cb, k, fdb, urb, nb, hi;
    bit pc;
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; bright = 8'd255; br_frame = 8'd255;
    start32 = 1'b0; pv32 = 1'b0; pix32 = 32'h11223344;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_comm", 32'(comm), 0);
    check("rst_ready", 32'(rdy), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(fd), 0);
    check("rst_underrun", 32'(ur), 0);
    // back-to-back frame, length and pixel order
    feed = '{24'hFF0000, 24'h0000FF};
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(rdy), 0);
    do_start();
    wait_rise("t1_first_high");
    run_frame(n, nu, ha);
    check("t1_frame_len", 32'(n), 32'(N * 24 * B + R));
    check("t1_no_underrun", 32'(nu), 0);
    check("t1_drained", 32'(exp_q.size()), 0);
    @(negedge clk);
    check("t1_idle", 32'(busy), 0);
    // underrun: second pixel withheld
    feed = '{24'h123456};
    urb = ur_cnt;
    do_start();
    wait_rise("t2_first_high");
    run_frame(n, nu, ha);
    check("t2_underrun_at", 32'(nu), 32'(24 * B));
    check("t2_frame_len", 32'(n), 32'(24 * B + R));
    check("t2_latch_low", 32'(ha), 0);
    check("t2_underrun_cnt", 32'(ur_cnt - urb), 1);
    check("t2_drained", 32'(exp_q.size()), 0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("t2_start_on_done_ignored", 32'(busy), 0);
    // valid held for 5 pixels; a mid-frame start is ignored
    base = hs_cnt;
    feed = '{24'h010203, 24'h808080, 24'h0F0F0F, 24'hAAAAAA, 24'h555555};
    do_start();
    late = 0; cb = hs_cnt; k = 0;
    while (!fd && k < 1000) begin
      @(negedge clk); #1;
      if (cb - base >= 2 && rdy) late++;
      cb = hs_cnt;
      k++;
      start = k == 100;
    end
    start = 1'b0;
    check("t3_frame_done", 32'(fd), 1);
    check("t3_handshakes", 32'(hs_cnt - base), 2);
    check("t3_ready_after_full", 32'(late), 0);
    check("t3_drained", 32'(exp_q.size()), 0);
    feed.delete();
    @(negedge clk);
    check("t3_ready_idle", 32'(rdy), 0);
    check("t3_busy_idle", 32'(busy), 0);
    // reset during bit 10 of pixel 0
    feed = '{24'hA5A5A5, 24'h5A5A5A};
    do_start();
    wait_rise("t4_first_high");
    repeat (82) @(negedge clk);
    check("t4_pre_reset_high", 32'(comm), 1);
    fdb = fd_cnt; urb = ur_cnt;
    rst = 1'b1;
    feed.delete();
    @(negedge clk);
    check("t4_comm_low", 32'(comm), 0);
    check("t4_busy_low", 32'(busy), 0);
    check("t4_ready_low", 32'(rdy), 0);
    rst = 1'b0;
    repeat (420) @(negedge clk);
    check("t4_no_done_pulse", 32'(fd_cnt - fdb), 0);
    check("t4_no_underrun_pulse", 32'(ur_cnt - urb), 0);
    feed = '{24'hC33C96, 24'h5AA55A};
    do_start();
    wait_rise("t4_fresh_first_high");
    run_frame(n, nu, ha);
    check("t4_fresh_len", 32'(n), 32'(N * 24 * B + R));
    check("t4_fresh_drained", 32'(exp_q.size()), 0);
    // 32-bit RGBW word ordering
    @(posedge clk); #1;
    pv32 = 1'b1; start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    k = 0;
    while (!comm32 && k < 200) begin @(negedge clk); k++; end
    check("t5_first_high", 32'(comm32), 1);
    n = 1; hi = 1; nb = 0; w = '0; pc = 1;
    while (!fd32 && n < 1000) begin
      @(negedge clk);
      n++;
      if (comm32) hi++;
      else if (pc) begin
        w = {w[30:0], hi == T1};
        nb++;
        hi = 0;
      end
      pc = comm32;
    end
    pv32 = 1'b0;
    check("t5_word", w, 32'h22113344);
    check("t5_bits", 32'(nb), 32);
    check("t5_frame_len", 32'(n), 32'(32 * B + R));
    @(negedge clk);
    check("t5_busy", 32'(busy32), 0);
    check("t5_ready", 32'(rdy32), 0);
    check("t5_underrun", 32'(ur32), 0);
    // brightness 127 then 0
    bright = 8'd127;
    feed = '{24'hFF8040, 24'hFF8040};
    do_start();
    wait_rise("t6_first_high");
    run_frame(n, nu, ha);
    check("t6_len", 32'(n), 32'(N * 24 * B + R));
    check("t6_drained", 32'(exp_q.size()), 0);
    bright = 8'd0;
    feed = '{24'hFF8040, 24'h123456};
    do_start();
    wait_rise("t6_zero_first_high");
    run_frame(n, nu, ha);
    check("t6_zero_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ws2812_stream_driver.md
Name: ws2812_stream_driver

Overview:
Parametrised serial driver for WS2812-family addressable LED strips. It takes a stream of per-pixel colour words over a valid/ready handshake and emits the one-wire NRZ waveform, green-first and MSB-first. It supports a programmable strip length, 24-bit RGB or 32-bit RGBW pixels, and parameterised bit timing. A one-pixel prefetch buffer keeps consecutive pixels gap-free, and the frame ends with a timed latch period. It sits between the frame/pixel-fetch logic and the strip output pin.

Parameters:
- NUM_LEDS, 256: pixels per frame (1..4096).
- COLOR_BITS, 24: pixel width. 24 = {R,G,B}; 32 = {R,G,B,W}. Any other value is illegal.
- T0H_CYC, 26: high cycles for a '0' bit (400 ns at 65 MHz).
- T1H_CYC, 52: high cycles for a '1' bit (800 ns at 65 MHz).
- BIT_CYC, 81: total cycles per bit. Requires 0 < T0H_CYC < T1H_CYC < BIT_CYC.
- RESET_CYC, 3250: low cycles of the latch period (50 us at 65 MHz).

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- start_in, input, 1: frame start pulse. Honoured only in IDLE.
- pixel_in, input, COLOR_BITS: pixel word, R in the MSB byte.
- pixel_valid_in, input, 1: pixel_in is valid.
- pixel_ready_out, output, 1: driver accepts pixel_in this cycle.
- brightness_in, input, 8: global brightness. Used only with the optional feature.
- busy_out, output, 1: high whenever state is not IDLE.
- frame_done_out, output, 1: one-cycle pulse at the end of the latch period.
- underrun_out, output, 1: one-cycle pulse when a frame is aborted for lack of data.
- comm, output, 1: strip data line.

Behaviour:
- Clock and reset: single clock clk_in. rst_in is synchronous and active-high.
- Reset values: comm=0, pixel_ready_out=0, busy_out=0, frame_done_out=0, underrun_out=0, state=IDLE, prefetch buffer empty, all counters 0.
- Reset mid-frame: comm is low on the next edge and the frame is discarded. No frame_done_out or underrun_out pulse is generated.
- States: IDLE, WAIT_FIRST, SEND, LATCH.
- IDLE: comm=0, pixel_ready_out=0. start_in=1 -> WAIT_FIRST; the accepted-pixel and sent-pixel counters clear.
- Handshake: a transfer occurs when pixel_valid_in && pixel_ready_out. pixel_ready_out = (state is not IDLE or LATCH) && buffer empty && accepted-pixel count < NUM_LEDS. It is a registered/combinational function of state only, never of pixel_valid_in.
- WAIT_FIRST: comm=0. Waits with no timeout until the buffer holds a pixel. Then the shift register loads from the buffer, the buffer empties, and the state moves to SEND with bit 0 starting on the next cycle.
- Transmit word: {G,R,B} for 24-bit pixels, {G,R,B,W} for 32-bit pixels, MSB first.
- SEND bit timing: cycle counter c runs 0..BIT_CYC-1. comm=1 while c < THIGH, else 0, where THIGH is T1H_CYC for a '1' bit and T0H_CYC for a '0' bit.
- End of bit: when c=BIT_CYC-1, advance to the next bit.
- Pixel boundary, last bit of a pixel with c=BIT_CYC-1:
  - If this was pixel NUM_LEDS-1 -> LATCH.
  - Else if the buffer is full -> load the shift register the same cycle. No idle cycle between pixels.
  - Else -> underrun: pulse underrun_out, go to LATCH. The frame is aborted; frame_done_out still pulses at the end of LATCH.
- LATCH: comm=0 for exactly RESET_CYC cycles. On the last cycle frame_done_out=1 and the state moves to IDLE.
- start_in while busy is ignored. start_in on the cycle frame_done_out pulses is ignored.
- Counter widths: cycle counter is $clog2(max(BIT_CYC,RESET_CYC)). Bit counter is $clog2(COLOR_BITS). Pixel counters are $clog2(NUM_LEDS+1). There is no wrap within a frame.
- Frame length: exactly NUM_LEDS*COLOR_BITS*BIT_CYC + RESET_CYC cycles from the first SEND cycle to frame_done_out, given no underrun.

Optional Feature:
- Macro: WS2812_BRIGHTNESS_EN.
- When defined: brightness_in is sampled on the cycle start_in is accepted and held for the frame. Each 8-bit channel is scaled at shift-register load as ch_out = (ch * (brightness+1)) >> 8, using a 16-bit intermediate, so 255 is identity and 0 gives 0.
- When undefined: brightness_in is unused and channels are sent unmodified.

Test Plan:
Test parameters: NUM_LEDS=2, COLOR_BITS=24, T0H=2, T1H=5, BIT=8, RESET=20.
1. start_in; pixels 0xFF0000 and 0x0000FF presented back-to-back -> first pixel sends G=0x00, R=0xFF, B=0x00. Bit 8 (R MSB) has comm high 5 cycles then low 3. No gap between pixels. frame_done_out pulses 2*24*8+20=404 cycles after the first SEND cycle.
2. Second pixel withheld -> underrun_out pulses at the end of bit 23 of pixel 0. comm stays low 20 cycles, then frame_done_out pulses and busy_out drops.
3. pixel_valid_in held high for 5 pixels -> exactly 2 handshakes. pixel_ready_out stays 0 after the second handshake until the next frame.
4. rst_in asserted at bit 10 of pixel 0 -> comm=0 on the next cycle. All outputs reach reset values with no pulses. A fresh start_in sends a complete correct frame.
5. COLOR_BITS=32, pixel 0x11223344 -> transmitted bit stream is 0x22113344 MSB first.
6. With WS2812_BRIGHTNESS_EN defined, brightness_in=127, pixel 0xFF8040 -> sent G=0x40, R=0x7F, B=0x20. With brightness_in=0, all bits are '0' pulses (2-cycle highs).
